// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode constants, vote helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // 2-of-3 majority
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: 2-FF synchroniser and 3-sample mid-bit vote.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned OVS   = 16,
   parameter int unsigned CNT_W = $clog2(OVS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   input  logic             rx_tick,
   input  logic [CNT_W-1:0] tick_cnt,
   output logic             rx_s,
   output logic             vote
);

   localparam logic [CNT_W-1:0] T_S0 = CNT_W'(OVS/2 - 1);
   localparam logic [CNT_W-1:0] T_S1 = CNT_W'(OVS/2);

   logic rx_meta;
   logic smp0;
   logic smp1;

   // Two-stage synchroniser, idles high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Capture the two early samples; the third is the live value at the vote tick
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         smp0 <= 1'b1;
         smp1 <= 1'b1;
      end else if (rx_tick) begin
         if (tick_cnt == T_S0) smp0 <= rx_s;
         if (tick_cnt == T_S1) smp1 <= rx_s;
      end
   end

   assign vote = maj3(smp0, smp1, rx_s);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority vote, parity, 1/2 stop bits, break detect
// and a single-entry valid/ready output buffer with overrun reporting.
module uart_rx_ovs
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OVS    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_tick,
   input  logic              rx,
   input  logic              par_en,
   input  logic              par_odd,
   input  logic              stop2,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_perr,
   output logic              m_ferr,
   output logic              ovr_err,
   output logic              brk_det,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(OVS);
   localparam int unsigned IDX_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] T_VOTE   = CNT_W'(OVS/2 + 1);
   localparam logic [CNT_W-1:0] T_LAST   = CNT_W'(OVS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   rx_state_t          state_q, state_d;
   logic [CNT_W-1:0]   tick_q, tick_d, tick_nxt;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               pbit_q, pbit_d;
   logic               stop1_q, stop1_d;
   logic               ferr_acc_q, ferr_acc_d;
   logic               stop_hi_q, stop_hi_d;
   logic               pen_q, pen_d;
   logic               podd_q, podd_d;
   logic               s2_q, s2_d;

   logic               m_valid_d, m_perr_d, m_ferr_d, ovr_err_d, brk_det_d, busy_d;
   logic [DATA_W-1:0]  m_data_d;

   logic               done_c, frame_perr_c, frame_ferr_c, frame_brk_c;
   logic               rx_s, vote;

   uart_rx_sampler #(
      .OVS   (OVS),
      .CNT_W (CNT_W)
   ) u_sampler (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rx_tick  (rx_tick),
      .tick_cnt (tick_q),
      .rx_s     (rx_s),
      .vote     (vote)
   );

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         tick_q     <= '0;
         idx_q      <= '0;
         data_q     <= '0;
         pbit_q     <= 1'b0;
         stop1_q    <= 1'b0;
         ferr_acc_q <= 1'b0;
         stop_hi_q  <= 1'b0;
         pen_q      <= 1'b0;
         podd_q     <= 1'b0;
         s2_q       <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_perr     <= 1'b0;
         m_ferr     <= 1'b0;
         ovr_err    <= 1'b0;
         brk_det    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         pbit_q     <= pbit_d;
         stop1_q    <= stop1_d;
         ferr_acc_q <= ferr_acc_d;
         stop_hi_q  <= stop_hi_d;
         pen_q      <= pen_d;
         podd_q     <= podd_d;
         s2_q       <= s2_d;
         m_valid    <= m_valid_d;
         m_data     <= m_data_d;
         m_perr     <= m_perr_d;
         m_ferr     <= m_ferr_d;
         ovr_err    <= ovr_err_d;
         brk_det    <= brk_det_d;
         busy       <= busy_d;
      end
   end

   // Frame FSM: bit timing, data capture and completion flags, advanced only on rx_tick
   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      idx_d        = idx_q;
      data_d       = data_q;
      pbit_d       = pbit_q;
      stop1_d      = stop1_q;
      ferr_acc_d   = ferr_acc_q;
      stop_hi_d    = stop_hi_q;
      pen_d        = pen_q;
      podd_d       = podd_q;
      s2_d         = s2_q;
      done_c       = 1'b0;
      frame_perr_c = 1'b0;
      frame_ferr_c = 1'b0;
      frame_brk_c  = 1'b0;
      tick_nxt     = (tick_q == T_LAST) ? '0 : tick_q + CNT_W'(1);

      if (rx_tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d    = ST_START;
                  tick_d     = '0;
                  pen_d      = par_en;
                  podd_d     = par_odd;
                  s2_d       = stop2;
                  stop1_d    = 1'b0;
                  ferr_acc_d = 1'b0;
                  stop_hi_d  = 1'b0;
               end
            end
            ST_START: begin
               tick_d = tick_nxt;
               if (tick_q == T_VOTE && vote) begin
                  state_d = ST_IDLE;
                  tick_d  = '0;
               end else if (tick_q == T_LAST) begin
                  state_d = ST_DATA;
                  idx_d   = '0;
               end
            end
            ST_DATA: begin
               tick_d = tick_nxt;
               if (tick_q == T_VOTE) data_d[idx_q] = vote;
               if (tick_q == T_LAST) begin
                  if (idx_q == IDX_LAST) begin
                     idx_d   = '0;
                     state_d = pen_q ? ST_PARITY : ST_STOP;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            ST_PARITY: begin
               tick_d = tick_nxt;
               if (tick_q == T_VOTE) pbit_d = vote;
               if (tick_q == T_LAST) state_d = ST_STOP;
            end
            ST_STOP: begin
               tick_d = tick_nxt;
               if (tick_q == T_VOTE) begin
                  if (s2_q && !stop1_q) begin
                     stop1_d    = 1'b1;
                     ferr_acc_d = ferr_acc_q | ~vote;
                     stop_hi_d  = stop_hi_q | vote;
                  end else begin
                     // Final stop vote: finish half a bit early to catch a back-to-back start
                     done_c       = 1'b1;
                     frame_ferr_c = ferr_acc_q | ~vote;
                     if (pen_q) begin
                        frame_perr_c = (podd_q == PAR_ODD) ? ~^{data_q, pbit_q}
                                                           :  ^{data_q, pbit_q};
                     end
                     frame_brk_c  = (data_q == '0) && !(pen_q && pbit_q) &&
                                    !(stop_hi_q | vote);
                     state_d      = frame_ferr_c ? ST_WAIT_IDLE : ST_IDLE;
                     tick_d       = '0;
                  end
               end
            end
            ST_WAIT_IDLE: begin
               if (rx_s) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               tick_d  = '0;
            end
         endcase
      end
   end

   // Single-entry output buffer: load on completion when free, else flag overrun
   always_comb begin
      m_valid_d = m_valid;
      m_data_d  = m_data;
      m_perr_d  = m_perr;
      m_ferr_d  = m_ferr;
      ovr_err_d = 1'b0;
      brk_det_d = 1'b0;
      busy_d    = (state_d != ST_IDLE);

      if (done_c) begin
         brk_det_d = frame_brk_c;
         if (!m_valid || m_ready) begin
            m_valid_d = 1'b1;
            m_data_d  = data_q;
            m_perr_d  = frame_perr_c;
            m_ferr_d  = frame_ferr_c;
         end else begin
            ovr_err_d = 1'b1;
         end
      end else if (m_valid && m_ready) begin
         m_valid_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx_ovs;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned OVS      = 16;
   localparam int unsigned TICK_DIV = 4;

   logic              clk     = 1'b0;
   logic              rst     = 1'b0;
   logic              rx_tick = 1'b0;
   logic              rx      = 1'b1;
   logic              par_en  = 1'b0;
   logic              par_odd = 1'b0;
   logic              stop2   = 1'b0;
   logic              m_ready = 1'b1;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_perr;
   logic              m_ferr;
   logic              ovr_err;
   logic              brk_det;
   logic              busy;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } frame_t;

   frame_t exp_q[$];
   frame_t got_f;
   int n_cmp      = 0;
   int n_bad      = 0;
   int ovr_seen   = 0;
   int brk_seen   = 0;
   int exp_ovr    = 0;
   int exp_brk    = 0;
   int frames_seen = 0;
   int div_cnt    = 0;

   uart_rx_ovs #(.DATA_W(DATA_W), .OVS(OVS)) dut (
      .clk     (clk),
      .rst     (rst),
      .rx_tick (rx_tick),
      .rx      (rx),
      .par_en  (par_en),
      .par_odd (par_odd),
      .stop2   (stop2),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_perr  (m_perr),
      .m_ferr  (m_ferr),
      .ovr_err (ovr_err),
      .brk_det (brk_det),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Baud tick: one clk in TICK_DIV, changed on the falling edge
   always @(negedge clk) begin
      div_cnt <= (div_cnt == TICK_DIV - 1) ? 0 : div_cnt + 1;
      rx_tick <= (div_cnt == TICK_DIV - 1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Consumer side: every accepted frame is compared against the model queue
   always @(negedge clk) begin
      if (rst) begin
         if (m_valid && m_ready) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
               got_f = exp_q.pop_front();
               check("m_data", 32'(m_data), 32'(got_f.data));
               check("m_perr", 32'(m_perr), 32'(got_f.perr));
               check("m_ferr", 32'(m_ferr), 32'(got_f.ferr));
            end
         end
         if (ovr_err) ovr_seen++;
         if (brk_det) brk_seen++;
      end
   end

   // Wait n rx_tick pulses, then step just past the edge
   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!rx_tick) @(posedge clk);
      end
      #1;
   endtask

   task automatic drive(input logic v, input int n);
      rx = v;
      ticks(n);
   endtask

   // Reference model of one frame from its line-level fields, then the line itself
   task automatic send_frame(input logic [7:0] d, input logic pe, input logic po,
                             input logic s2, input logic pbit, input logic st0,
                             input logic st1, input bit drop, input bit scramble);
      frame_t f;
      bit     brk;
      f.data = d;
      f.perr = pe && ((($countones(d) + int'(pbit)) % 2) != (po ? 1 : 0));
      f.ferr = !st0 || (s2 && !st1);
      brk    = (d == 8'h00) && !(pe && pbit) && !st0 && (!s2 || !st1);
      if (drop) exp_ovr++;
      else      exp_q.push_back(f);
      if (brk) exp_brk++;
      par_en  = pe;
      par_odd = po;
      stop2   = s2;
      rx = 1'b0;
      ticks(4);
      if (scramble) begin
         par_en  = 1'($urandom);
         par_odd = 1'($urandom);
         stop2   = 1'($urandom);
      end
      ticks(OVS - 4);
      for (int i = 0; i < 8; i++) drive(d[i], OVS);
      if (pe) drive(pbit, OVS);
      drive(st0, OVS);
      if (s2) drive(st1, OVS);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int fs;
      logic [7:0] d;
      logic pe, po, s2, pb, st0, st1;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data",  32'(m_data),  0);
      check("rst_m_perr",  32'(m_perr),  0);
      check("rst_m_ferr",  32'(m_ferr),  0);
      check("rst_ovr",     32'(ovr_err), 0);
      check("rst_brk",     32'(brk_det), 0);
      check("rst_busy",    32'(busy),    0);
      rst = 1'b1;
      drive(1'b1, 2 * OVS);

      // Plain 8N1 frame
      send_frame(8'hA5, 0, 0, 0, 0, 1, 1, 0, 0);
      drive(1'b1, OVS);
      check("a5_drain", 32'(exp_q.size()), 0);
      check("a5_idle",  32'(busy), 0);

      // Even parity, wrong then right parity bit
      send_frame(8'h3C, 1, 0, 0, 1, 1, 1, 0, 0);
      drive(1'b1, OVS);
      send_frame(8'h3C, 1, 0, 0, 0, 1, 1, 0, 0);
      drive(1'b1, OVS);
      check("par_drain", 32'(exp_q.size()), 0);

      // Short low glitch is rejected
      fs = frames_seen;
      par_en = 0; stop2 = 0;
      rx = 1'b0;
      ticks(4);
      check("glitch_busy_hi", 32'(busy), 1);
      drive(1'b1, 2 * OVS);
      check("glitch_busy_lo", 32'(busy), 0);
      check("glitch_noframe", 32'(frames_seen - fs), 0);

      // One-tick spike inside a zero data bit is outvoted
      got_f.data = 8'h00; got_f.perr = 1'b0; got_f.ferr = 1'b0;
      exp_q.push_back(got_f);
      drive(1'b0, OVS);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            drive(1'b0, 9);
            drive(1'b1, 1);
            drive(1'b0, 6);
         end else begin
            drive(1'b0, OVS);
         end
      end
      drive(1'b1, 2 * OVS);
      check("spike_drain", 32'(exp_q.size()), 0);

      // Break: line low for 20 bit times
      fs = frames_seen;
      got_f.data = 8'h00; got_f.perr = 1'b0; got_f.ferr = 1'b1;
      exp_q.push_back(got_f);
      exp_brk++;
      drive(1'b0, 20 * OVS);
      check("brk_frames",  32'(frames_seen - fs), 1);
      check("brk_waiting", 32'(busy), 1);
      drive(1'b1, 2 * OVS);
      check("brk_count",   32'(brk_seen), 32'(exp_brk));
      check("brk_frames2", 32'(frames_seen - fs), 1);
      check("brk_idle",    32'(busy), 0);

      // Overrun: consumer stalled across two frames
      m_ready = 1'b0;
      send_frame(8'h11, 0, 0, 0, 0, 1, 1, 0, 0);
      drive(1'b1, OVS);
      send_frame(8'h22, 0, 0, 0, 0, 1, 1, 1, 0);
      drive(1'b1, OVS);
      check("ovr_count", 32'(ovr_seen), 32'(exp_ovr));
      check("ovr_valid", 32'(m_valid), 1);
      check("ovr_hold",  32'(m_data), 32'h11);
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      check("ovr_release", 32'(m_valid), 0);
      check("ovr_drain",   32'(exp_q.size()), 0);

      // Reset in the middle of a frame
      par_en = 0; stop2 = 0;
      drive(1'b0, OVS);
      for (int i = 0; i < 3; i++) drive(1'b1, OVS);
      ticks(5);
      fs = frames_seen;
      rst = 1'b0;
      #1;
      check("mid_rst_busy",  32'(busy),    0);
      check("mid_rst_data",  32'(m_data),  0);
      check("mid_rst_valid", 32'(m_valid), 0);
      rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b1, 2 * OVS);
      check("mid_rst_noframe", 32'(frames_seen - fs), 0);
      send_frame(8'h5A, 0, 0, 1, 0, 1, 1, 0, 0);
      drive(1'b1, OVS);
      check("stop2_drain", 32'(exp_q.size()), 0);

      // Randomized frames with mode changes after the start bit
      for (int n = 0; n < 24; n++) begin
         d   = 8'($urandom);
         pe  = 1'($urandom);
         po  = 1'($urandom);
         s2  = 1'($urandom);
         pb  = 1'($urandom);
         st0 = ($urandom_range(0, 5) != 0);
         st1 = ($urandom_range(0, 5) != 0);
         if (n % 6 == 5) d = 8'h00;
         send_frame(d, pe, po, s2, pb, st0, st1, 0, 1);
         if ((s2 ? st1 : st0) == 1'b1) drive(1'b1, OVS * $urandom_range(0, 2));
         else                          drive(1'b1, OVS * $urandom_range(1, 2));
      end
      drive(1'b1, 2 * OVS);
      check("rand_drain", 32'(exp_q.size()), 0);
      check("final_ovr",  32'(ovr_seen), 32'(exp_ovr));
      check("final_brk",  32'(brk_seen), 32'(exp_brk));
      check("final_idle", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
